// File: rtl/pipe_stage_reg_pkg.sv
// Shared defaults and state encoding for the pipe_stage_reg inter-stage register.
// Optional counters are enabled in the top by defining STAGE_PERF_EN.
package pipe_stage_reg_pkg;

  localparam int WIDTH     = 32;
  localparam int IR_W_DEF  = WIDTH;
  localparam int PC_W_DEF  = WIDTH - 2;
  localparam int CNT_W_DEF = 16;

  // ISA NOP encoding presented on out_ir whenever the stage holds nothing
  localparam logic [31:0] NOP_IR_DEF = 32'h0000_0000;

  // Encoded as {s_v, m_v}; ST_ILLEGAL (skid valid without main valid) is unreachable
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_HOLD    = 2'b01,
    ST_ILLEGAL = 2'b10,
    ST_SKID    = 2'b11
  } stage_state_e;

  function automatic stage_state_e state_of(input logic m_v, input logic s_v);
    return stage_state_e'({s_v, m_v});
  endfunction

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One data+valid register of the stage, used for both the main and the skid slot.
// Reset clears data and valid; clear drops only valid so the data stays stable.
module pipe_skid_entry #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with a 2-entry skid buffer and synchronous flush.
// Define STAGE_PERF_EN to build the saturating stall/bubble counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int               IR_W   = IR_W_DEF,
  parameter int               PC_W   = PC_W_DEF,
  parameter logic [IR_W-1:0]  NOP_IR = IR_W'(NOP_IR_DEF),
  parameter int               CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IR_W-1:0]  in_ir,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IR_W-1:0]  out_ir,
  output logic [PC_W-1:0]  out_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int E_W = IR_W + PC_W;

  logic           m_v, s_v;
  logic [E_W-1:0] m_data, s_data, m_data_d;
  logic           m_load, m_clr, s_load, s_clr, m_from_s;
  logic           in_ready_q, in_ready_d;
  logic           accept, drain;
  stage_state_e   st;

  assign st     = state_of(m_v, s_v);
  assign accept = in_valid & in_ready_q;
  assign drain  = m_v & out_ready;

  always_comb begin
    m_load   = 1'b0;
    m_clr    = 1'b0;
    s_load   = 1'b0;
    s_clr    = 1'b0;
    m_from_s = 1'b0;
    unique case (st)
      ST_EMPTY: m_load = accept;
      ST_HOLD: begin
        if (accept && drain)  m_load = 1'b1;
        else if (accept)      s_load = 1'b1;
        else if (drain)       m_clr  = 1'b1;
      end
      ST_SKID: begin
        // in_ready is low here, so only the skid entry can move forward
        if (drain) begin
          m_load   = 1'b1;
          m_from_s = 1'b1;
          s_clr    = 1'b1;
        end
      end
      default: begin
        m_clr = 1'b1;
        s_clr = 1'b1;
      end
    endcase
    // Flush wins: loads suppressed so out_pc keeps its last value
    if (flush) begin
      m_load   = 1'b0;
      s_load   = 1'b0;
      m_from_s = 1'b0;
      m_clr    = 1'b1;
      s_clr    = 1'b1;
    end
    m_data_d   = m_from_s ? s_data : {in_ir, in_pc};
    in_ready_d = !((s_v && !s_clr) || s_load);
  end

  pipe_skid_entry #(.W(E_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (m_load),
    .clr_i   (m_clr),
    .data_i  (m_data_d),
    .valid_o (m_v),
    .data_o  (m_data)
  );

  pipe_skid_entry #(.W(E_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (s_load),
    .clr_i   (s_clr),
    .data_i  ({in_ir, in_pc}),
    .valid_o (s_v),
    .data_o  (s_data)
  );

  always_ff @(posedge clk) begin
    if (rst) in_ready_q <= 1'b1;
    else     in_ready_q <= in_ready_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_v;
  assign out_ir    = m_v ? m_data[E_W-1 -: IR_W] : NOP_IR;
  assign out_pc    = m_data[PC_W-1:0];

`ifdef STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;

  // Flush deliberately leaves the counters alone; only reset clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (m_v && !out_ready && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (!m_v && out_ready && (bubble_cnt_q != '1))
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed IF-to-ID inter-stage register.
- Carries an instruction word plus PC between any two pipeline stages (IF/ID, ID/EX, ...) using a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
- Provides full throughput under backpressure without a combinational ready path; flush inserts bubbles for branch redirects.

Parameters:
- IR_W, 32, instruction word width.
- PC_W, 30, PC width (word-addressed; equals WIDTH-2 at defaults).
- NOP_IR, 32'h0000_0000, IR value driven on out_ir whenever out_valid=0.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream has a word.
- in_ready  out  1  stage can accept; registered output.
- in_ir  in  IR_W  upstream instruction.
- in_pc  in  PC_W  upstream PC.
- flush  in  1  synchronous kill of all held entries.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_ir  out  IR_W  held instruction.
- out_pc  out  PC_W  held PC.
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready (STAGE_PERF_EN only).
- bubble_cnt  out  CNT_W  cycles with out_valid=0 & out_ready=1 (STAGE_PERF_EN only).

Behaviour:
- Storage:
  - Main register (M): drives the outputs.
  - Skid register (S): holds the overflow entry.
  - Valid bits m_v and s_v.
- States: EMPTY (m_v=0, s_v=0), HOLD (m_v=1, s_v=0), SKID (m_v=1, s_v=1). State m_v=0, s_v=1 is illegal and unreachable.
- Definitions:
  - in_ready = !s_v, taken from a flop; no combinational path from out_ready.
  - Accept when in_valid & in_ready.
  - Drain when out_valid & out_ready.
- Transitions:
  - EMPTY + accept -> HOLD; M <= input.
  - HOLD + accept & drain -> HOLD; M <= input.
  - HOLD + accept & !drain -> SKID; S <= input.
  - HOLD + !accept & drain -> EMPTY.
  - HOLD + neither -> HOLD.
  - SKID + drain -> HOLD; M <= S. No accept is possible in SKID (in_ready=0).
  - SKID + !drain -> SKID.
- Latency: an accepted word appears on the outputs the cycle after acceptance. Sustained throughput is 1 word/cycle.
- Ordering: strict FIFO. S is never bypassed.
- out_valid = m_v. out_ir = m_v ? M.ir : NOP_IR. out_pc = M.pc; its value is don't-care when !m_v, but is held stable.
- Output stability: while out_valid=1 and out_ready=0, out_ir and out_pc stay stable.
- flush:
  - Next state EMPTY; m_v and s_v cleared; in_ready=1 next cycle.
  - A simultaneous accept is discarded.
  - A simultaneous drain completes downstream; the stage does not re-issue that word.
- rst:
  - Same clearing as flush, and rst has priority over flush.
  - Reset values: out_valid=0, in_ready=1, out_ir=NOP_IR, out_pc=0, counters=0.
- Reset asserted mid-transfer discards all held entries.

Optional Feature:
- Macro STAGE_PERF_EN.
- Defined:
  - stall_cnt and bubble_cnt increment per the definitions above, saturating at all-ones.
  - Both clear on rst only; flush does not clear them.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package/header (params.v):
  - NOP_IR default (ISA NOP encoding).
  - Default IR_W/PC_W derived from WIDTH.
  - State encodings ST_EMPTY, ST_HOLD, ST_SKID.
- One sub-module, pipe_skid_entry: a data+valid register with load and clear enables, instantiated twice (M and S).
- Proc replaces the fixed IF/ID register with pipe_stage_reg at default parameters.

Test Plan:
- Reset / streaming:
  - Stimulus: rst=1 for 2 cycles, then release with out_ready=1.
  - Response: out_valid=0, out_ir=32'h0, in_ready=1.
  - Then stream IR=0x11,0x22,0x33 with PC=1,2,3 on consecutive cycles.
  - Response: each appears one cycle later, back-to-back, in order.
- Backpressure / skid:
  - Stimulus: out_ready=0, then push 0xA1 and 0xA2.
  - Response: state SKID, in_ready=0 in the cycle after the second accept, out_ir=0xA1 held stable.
  - Stimulus: raise out_ready.
  - Response: 0xA1 then 0xA2 delivered; in_ready=1 one cycle after the first drain.
- Simultaneous accept and drain in HOLD:
  - Stimulus: in HOLD with 0xB1, push 0xB2 while out_ready=1.
  - Response: next cycle out_ir=0xB2, s_v=0.
- Flush in SKID with a new word present:
  - Stimulus: flush in SKID while in_valid=1 with 0xC3.
  - Response: next cycle out_valid=0, out_ir=NOP_IR, in_ready=1; 0xC3 never appears.
- rst versus flush priority:
  - Stimulus: assert rst and flush together while counters are non-zero.
  - Response: with STAGE_PERF_EN, counters=0; without the macro, counter ports read 0 throughout.
- Counter saturation:
  - Stimulus: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles.
  - Response: stall_cnt saturates at 4'hF.
